gradient_engine: RTL and testbench
==================================

// Module: gradient_engine
// PURPOSE
//  Second-generation image gradient unit: for every pixel of a WIDTH x HEIGHT frame it
//  reads the left/right/up/down neighbours from a source BRAM and emits the x and y
//  gradients together in one output beat.
//  Adds runtime difference modes, a configurable read latency, output backpressure
//  (valid/ready) and abort. Sits between a blurred-octave BRAM and the x/y gradient BRAMs
//  that feed orientation/keypoint logic.
// PARAMETERS
//  WIDTH         64  frame width in pixels (>=2)
//  HEIGHT        64  frame height in pixels (>=2)
//  BIT_DEPTH     8   unsigned source pixel width
//  READ_LATENCY  2   cycles from ext_read_valid to ext_pixel_in being valid (>=1)
// PORTS
//  clk_in          in   1                       system clock
//  rst_in          in   1                       async active-high reset
//  start_in        in   1                       1-cycle pulse, begin frame (ignored while busy_out)
//  abort_in        in   1                       1-cycle pulse, cancel frame
//  mode_in         in   2                       0=central/2, 1=central full, 2=forward, 3=rsvd(as 0)
//  ext_read_addr   out  $clog2(WIDTH*HEIGHT)    source BRAM address
//  ext_read_valid  out  1                       read strobe, one per issued address
//  ext_pixel_in    in   BIT_DEPTH               source data, READ_LATENCY after strobe
//  out_addr        out  $clog2(WIDTH*HEIGHT)    centre pixel address, x + y*WIDTH
//  out_gx          out  BIT_DEPTH+1             signed x gradient
//  out_gy          out  BIT_DEPTH+1             signed y gradient
//  out_valid       out  1                       output beat valid
//  out_ready       in   1                       downstream accepts beat
//  busy_out        out  1                       high from start accept until done/abort
//  done_out        out  1                       1-cycle pulse after last beat accepted
// BEHAVIOUR
//  - Async reset: state=IDLE; every output 0; counters 0.
//  - States: IDLE -> ISSUE -> WAIT -> WRITE -> (ISSUE | DONE) ; DONE -> IDLE.
//  - IDLE: start_in latches mode_in into mode_q, cx=cy=0, busy_out=1 next cycle -> ISSUE.
//  - ISSUE: 4 consecutive cycles, ext_read_valid=1, addresses in order L,R,U,D:
//    central (0/1/3): L=(max(cx-1,0),cy) R=(min(cx+1,W-1),cy) U=(cx,max(cy-1,0)) D=(cx,min(cy+1,H-1))
//    forward (2):     L=(cx,cy) R=(min(cx+1,W-1),cy) U=(cx,cy) D=(cx,min(cy+1,H-1))
//  - Returning data tagged by a READ_LATENCY-deep valid/index pipe; sample k captured
//    exactly READ_LATENCY cycles after issue k. WAIT holds until D captured.
//  - Compute in BIT_DEPTH+2 signed: dx=R-L, dy=D-U (zero-extended operands).
//    mode 0/3: g=dx>>>1 (arith, floor: -255 -> -128, 255 -> 127); mode 1,2: g=dx (fits BIT_DEPTH+1).
//  - Border clamping yields 0 in forward mode at x=W-1 / y=H-1, half-difference at central borders.
//  - Latency: first issue in cycle t -> out_valid registered high in cycle t+4+READ_LATENCY.
//  - WRITE: out_valid, out_addr, out_gx, out_gy held stable until out_valid&&out_ready;
//    on that cycle advance raster (cx++, wrap to 0 and cy++) -> ISSUE; last pixel -> DONE.
//  - DONE: done_out=1 for one cycle, busy_out=0, -> IDLE. Exactly WIDTH*HEIGHT beats per frame.
//  - abort_in (any non-IDLE state): next cycle IDLE, out_valid=0, ext_read_valid=0,
//    busy_out=0, no done_out; in-flight read returns discarded. abort_in wins over start_in.
//  - start_in while busy ignored; mode_in changes mid-frame ignored.
//  - ext_read_valid never high outside ISSUE; ext_read_addr undefined when strobe low.
// TESTING  (WIDTH=4, HEIGHT=4, READ_LATENCY=2, pixel=addr*10 unless noted)
//  1 mode0, out_ready=1 -> 16 beats in raster; (1,1): gx=10, gy=40; (0,0): gx=5, gy=20; done_out once.
//  2 mode2 -> (3,2): gx=0, gy=40; (1,1): gx=10, gy=40; mode1 (1,1): gx=20, gy=80.
//  3 pixel (0,0)=255, (1,0)=0, mode1 -> beat (0,0) gx=-255; mode0 -> gx=-128 (9'h180).
//  4 out_ready low 5 cycles on beat 3 -> outputs stable, no new reads issued, no beat lost/duplicated.
//  5 abort_in during beat 7 WAIT -> IDLE next cycle, no done_out; new start -> clean 16-beat frame.
//  6 rst_in asserted mid-ISSUE asynchronously -> all outputs 0 immediately; start_in pulse while busy ignored.

Source files
------------

// File: rtl/gradient_engine.sv
// Image gradient unit: fetches L/R/U/D neighbours per pixel from a source BRAM
// and emits x/y gradients in one valid/ready beat, raster order.
module gradient_engine #(
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 64,
  parameter int BIT_DEPTH    = 8,
  parameter int READ_LATENCY = 2,
  localparam int AW = $clog2(WIDTH*HEIGHT),
  localparam int GW = BIT_DEPTH + 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 abort_in,
  input  logic [1:0]           mode_in,
  output logic [AW-1:0]        ext_read_addr,
  output logic                 ext_read_valid,
  input  logic [BIT_DEPTH-1:0] ext_pixel_in,
  output logic [AW-1:0]        out_addr,
  output logic [GW-1:0]        out_gx,
  output logic [GW-1:0]        out_gy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [XW-1:0]         r_cx;
  logic [YW-1:0]         r_cy;
  logic                  r_rd_valid;
  logic [1:0]            r_rd_idx;
  logic [AW-1:0]         r_rd_addr;
  logic                  r_out_valid;
  logic [AW-1:0]         r_out_addr;
  logic [GW-1:0]         r_gx;
  logic [GW-1:0]         r_gy;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pv [READ_LATENCY];
  logic [1:0]            r_pk [READ_LATENCY];
  logic [BIT_DEPTH-1:0]  r_l;
  logic [BIT_DEPTH-1:0]  r_r;
  logic [BIT_DEPTH-1:0]  r_u;

  logic                  w_cap;
  logic [1:0]            w_ck;
  logic                  w_fwd;
  logic                  w_half;
  logic                  w_last_x;
  logic                  w_last;
  logic [XW-1:0]         w_nx;
  logic [YW-1:0]         w_ny;
  logic [GW:0]           w_dx;
  logic [GW:0]           w_dy;
  logic [GW-1:0]         w_gx;
  logic [GW-1:0]         w_gy;
  logic [AW-1:0]         w_caddr;

  // Neighbour k (0=L,1=R,2=U,3=D) with border clamping.
  function automatic logic [AW-1:0] f_addr(
    input logic [XW-1:0] x,
    input logic [YW-1:0] y,
    input logic [1:0]    k,
    input logic          fwd
  );
    int ax;
    int ay;
    ax = int'(x);
    ay = int'(y);
    case (k)
      2'd0:    if (!fwd && ax > 0) ax = ax - 1;
      2'd1:    if (ax < WIDTH - 1) ax = ax + 1;
      2'd2:    if (!fwd && ay > 0) ay = ay - 1;
      default: if (ay < HEIGHT - 1) ay = ay + 1;
    endcase
    return AW'(ay * WIDTH + ax);
  endfunction

  assign w_cap    = r_pv[READ_LATENCY-1];
  assign w_ck     = r_pk[READ_LATENCY-1];
  assign w_fwd    = (r_mode == 2'd2);
  assign w_half   = (r_mode[0] == r_mode[1]);
  assign w_last_x = (r_cx == XW'(WIDTH - 1));
  assign w_last   = w_last_x && (r_cy == YW'(HEIGHT - 1));
  assign w_nx     = w_last_x ? '0 : r_cx + XW'(1);
  assign w_ny     = w_last_x ? r_cy + YW'(1) : r_cy;
  assign w_caddr  = AW'(int'(r_cy) * WIDTH + int'(r_cx));

  // D is used straight off the bus in the cycle it returns.
  assign w_dx = {2'b00, r_r} - {2'b00, r_l};
  assign w_dy = {2'b00, ext_pixel_in} - {2'b00, r_u};
  assign w_gx = w_half ? w_dx[GW:1] : w_dx[GW-1:0];
  assign w_gy = w_half ? w_dy[GW:1] : w_dy[GW-1:0];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pk[i] <= 2'd0;
      end
    end else if (abort_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
      end
    end else begin
      r_pv[0] <= r_rd_valid;
      r_pk[0] <= r_rd_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pk[i] <= r_pk[i-1];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_l <= '0;
      r_r <= '0;
      r_u <= '0;
    end else if (w_cap) begin
      case (w_ck)
        2'd0:    r_l <= ext_pixel_in;
        2'd1:    r_r <= ext_pixel_in;
        2'd2:    r_u <= ext_pixel_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'd0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_idx    <= 2'd0;
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_gx        <= '0;
      r_gy        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort_in && r_state != S_IDLE) begin
        r_state     <= S_IDLE;
        r_rd_valid  <= 1'b0;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_in && !abort_in) begin
              r_mode     <= mode_in;
              r_cx       <= '0;
              r_cy       <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_ISSUE;
              r_rd_valid <= 1'b1;
              r_rd_idx   <= 2'd0;
              r_rd_addr  <= f_addr('0, '0, 2'd0, mode_in == 2'd2);
            end
          end
          S_ISSUE: begin
            if (r_rd_idx == 2'd3) begin
              r_rd_valid <= 1'b0;
              r_state    <= S_WAIT;
            end else begin
              r_rd_idx  <= r_rd_idx + 2'd1;
              r_rd_addr <= f_addr(r_cx, r_cy, r_rd_idx + 2'd1, w_fwd);
            end
          end
          S_WAIT: begin
            if (w_cap && w_ck == 2'd3) begin
              r_out_valid <= 1'b1;
              r_out_addr  <= w_caddr;
              r_gx        <= w_gx;
              r_gy        <= w_gy;
              r_state     <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              if (w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_cx       <= w_nx;
                r_cy       <= w_ny;
                r_state    <= S_ISSUE;
                r_rd_valid <= 1'b1;
                r_rd_idx   <= 2'd0;
                r_rd_addr  <= f_addr(w_nx, w_ny, 2'd0, w_fwd);
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ext_read_addr  = r_rd_addr;
  assign ext_read_valid = r_rd_valid;
  assign out_addr       = r_out_addr;
  assign out_gx         = r_gx;
  assign out_gy         = r_gy;
  assign out_valid      = r_out_valid;
  assign busy_out       = r_busy;
  assign done_out       = r_done;

endmodule

// File: tb/tb_gradient_engine.sv
// Directed bench for gradient_engine on a 4x4 frame with a 2-cycle BRAM model.
module tb_gradient_engine;

  logic       clk_in;
  logic       rst_in;
  logic       start_in;
  logic       abort_in;
  logic [1:0] mode_in;
  logic [3:0] ext_read_addr;
  logic       ext_read_valid;
  logic [7:0] ext_pixel_in;
  logic [3:0] out_addr;
  logic [8:0] out_gx;
  logic [8:0] out_gy;
  logic       out_valid;
  logic       out_ready;
  logic       busy_out;
  logic       done_out;

  gradient_engine #(
    .WIDTH(4),
    .HEIGHT(4),
    .BIT_DEPTH(8),
    .READ_LATENCY(2)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start_in(start_in),
    .abort_in(abort_in),
    .mode_in(mode_in),
    .ext_read_addr(ext_read_addr),
    .ext_read_valid(ext_read_valid),
    .ext_pixel_in(ext_pixel_in),
    .out_addr(out_addr),
    .out_gx(out_gx),
    .out_gy(out_gy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy_out(busy_out),
    .done_out(done_out)
  );

  logic [7:0] mem [16];
  logic [7:0] rd1;
  int nchk = 0;
  int nerr = 0;
  int nreads = 0;
  int ndone = 0;
  int nbeats = 0;
  logic [3:0] b_addr [64];
  logic [8:0] b_gx [64];
  logic [8:0] b_gy [64];

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) begin
    rd1 <= mem[ext_read_addr];
    ext_pixel_in <= rd1;
  end

  always @(negedge clk_in) begin
    if (ext_read_valid) nreads++;
    if (done_out) ndone++;
    if (out_valid && out_ready) begin
      if (nbeats < 64) begin
        b_addr[nbeats] = out_addr;
        b_gx[nbeats] = out_gx;
        b_gy[nbeats] = out_gy;
      end
      nbeats++;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_g(input int x, input int y,
                                       input int m, input bit isy);
    int x0, y0, x1, y1, d;
    if (!isy) begin
      y0 = y; y1 = y;
      x0 = (m == 2) ? x : ((x > 0) ? x - 1 : 0);
      x1 = (x < 3) ? x + 1 : 3;
    end else begin
      x0 = x; x1 = x;
      y0 = (m == 2) ? y : ((y > 0) ? y - 1 : 0);
      y1 = (y < 3) ? y + 1 : 3;
    end
    d = int'(mem[y1*4+x1]) - int'(mem[y0*4+x0]);
    if (m == 1 || m == 2) return d[8:0];
    return 9'(d >>> 1);
  endfunction

  task automatic chk_frame(input int m);
    for (int i = 0; i < 16; i++) begin
      chk("raster_addr", b_addr[i], i);
      chk("beat_gx", b_gx[i], ref_g(i % 4, i / 4, m, 1'b0));
      chk("beat_gy", b_gy[i], ref_g(i % 4, i / 4, m, 1'b1));
    end
  endtask

  task automatic run_frame(input logic [1:0] m, input int stall_at,
                           input bit poke);
    int t, k, r0, d0, sr;
    logic [8:0] sx, sy;
    bit st;
    nbeats = 0;
    r0 = nreads;
    d0 = ndone;
    st = 0;
    mode_in = m;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    mode_in = m ^ 2'b01;
    t = 0;
    while (ndone == d0 && t < 3000) begin
      start_in = (poke && t == 20);
      if (stall_at >= 0 && !st && nbeats == stall_at) begin
        st = 1;
        out_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin
          step();
          k++;
        end
        sx = out_gx;
        sy = out_gy;
        sr = nreads;
        repeat (5) step();
        chk("stall_valid", out_valid, 1);
        chk("stall_addr", out_addr, stall_at);
        chk("stall_gx", out_gx, sx);
        chk("stall_gy", out_gy, sy);
        chk("stall_noread", nreads, sr);
        out_ready = 1'b1;
      end
      step();
      t++;
    end
    start_in = 1'b0;
    repeat (4) step();
    chk("frame_done", ndone - d0, 1);
    chk("frame_beats", nbeats, 16);
    chk("frame_reads", nreads - r0, 64);
    chk("frame_idle", busy_out, 0);
  endtask

  initial begin
    int k, r0, d0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 10);
    rst_in = 1'b1;
    start_in = 1'b0;
    abort_in = 1'b0;
    mode_in = 2'd0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_busy", busy_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_rd", ext_read_valid, 0);
    chk("rst_done", done_out, 0);
    chk("rst_gx", out_gx, 0);
    chk("rst_addr", out_addr, 0);
    rst_in = 1'b0;
    step();

    run_frame(2'd0, 3, 1'b0);
    chk_frame(0);
    chk("m0_11_gx", b_gx[5], 10);
    chk("m0_11_gy", b_gy[5], 40);
    chk("m0_00_gx", b_gx[0], 5);
    chk("m0_00_gy", b_gy[0], 20);
    chk("m0_33_gx", b_gx[15], 5);

    run_frame(2'd2, -1, 1'b0);
    chk_frame(2);
    chk("m2_32_gx", b_gx[11], 0);
    chk("m2_32_gy", b_gy[11], 40);
    chk("m2_11_gx", b_gx[5], 10);
    chk("m2_11_gy", b_gy[5], 40);

    run_frame(2'd1, -1, 1'b0);
    chk("m1_11_gx", b_gx[5], 20);
    chk("m1_11_gy", b_gy[5], 80);

    run_frame(2'd3, -1, 1'b0);
    chk_frame(3);

    mem[0] = 8'd255;
    mem[1] = 8'd0;
    run_frame(2'd1, -1, 1'b0);
    chk("neg_m1_gx", b_gx[0], 9'h101);
    chk("neg_m1_gy", b_gy[0], 9'h129);
    run_frame(2'd0, -1, 1'b0);
    chk("neg_m0_gx", b_gx[0], 9'h180);
    chk("neg_m0_gy", b_gy[0], 9'h194);
    mem[0] = 8'd0;
    mem[1] = 8'd10;

    nbeats = 0;
    d0 = ndone;
    mode_in = 2'd0;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    k = 0;
    while (nbeats != 7 && k < 500) begin
      step();
      k++;
    end
    r0 = nreads;
    k = 0;
    while (nreads != r0 + 4 && k < 50) begin
      step();
      k++;
    end
    chk("abort_in_wait", out_valid, 0);
    abort_in = 1'b1;
    start_in = 1'b1;
    step();
    abort_in = 1'b0;
    start_in = 1'b0;
    chk("abort_busy", busy_out, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_rd", ext_read_valid, 0);
    repeat (10) step();
    chk("abort_nodone", ndone - d0, 0);
    chk("abort_beats", nbeats, 7);
    chk("abort_stay_idle", busy_out, 0);

    run_frame(2'd0, -1, 1'b1);
    chk_frame(0);

    mode_in = 2'd0;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    k = 0;
    while (!ext_read_valid && k < 10) begin
      step();
      k++;
    end
    step();
    chk("pre_rst_rd", ext_read_valid, 1);
    chk("pre_rst_raddr", ext_read_addr, 1);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_rd", ext_read_valid, 0);
    chk("arst_raddr", ext_read_addr, 0);
    chk("arst_busy", busy_out, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_done", done_out, 0);
    step();
    rst_in = 1'b0;
    step();
    run_frame(2'd0, -1, 1'b0);
    chk_frame(0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
